alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one 4-bit ALU (AND/OR/XOR/ADD) between two requesters via valid/ready handshakes. Round-robin arbitration picks one request per cycle; the result is registered with the winner's ID and held until the consumer accepts it. Sits between two issue sources and a shared result consumer in the Pre-lab datapath.

## Interface
- No parameters. Data width is fixed at 4 bits, and there are 2 requesters.
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req0_valid` in 1: requester 0 presents an operation.
- `req0_ready` out 1: requester 0's operation is accepted this cycle.
- `req0_a`, `req0_b` in 4 each: operands for requester 0.
- `req0_op` in 2: opcode for requester 0. 00=AND, 01=OR, 10=XOR, 11=ADD.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as above, for requester 1.
- `resp_valid` out 1: the result register holds an unconsumed result.
- `resp_ready` in 1: the consumer takes the result this cycle.
- `resp_data` out 4: the ALU result.
- `resp_id` out 1: which requester produced the result.
- `resp_carry` out 1: carry-out of ADD. See Configuration.
- `op_count` out 8: number of results consumed, modulo 256.

## Operation
- **Result states**
  - EMPTY: `resp_valid`=0.
  - FULL: `resp_valid`=1.
- **Slot free:** `slot_free` = EMPTY, or (FULL and `resp_ready`=1).
- **Grant**
  - Only one `reqN_valid` is high: that requester wins.
  - Both are high: the requester other than `last_id` wins.
  - `last_id` resets to 1, so requester 0 wins the first tie.
- **Ready:** `reqN_ready` = `slot_free` and the grant is N. It is combinational, and at most one ready is high per cycle.
- **Accept:** an accept happens when `reqN_valid` && `reqN_ready`. At the clock edge:
  - the ALU result is loaded into `resp_data`;
  - N is loaded into `resp_id`;
  - N is loaded into `last_id`;
  - the state goes to FULL.
- **Transitions**
  - EMPTY, with an accept → FULL.
  - EMPTY, no accept → stays EMPTY.
  - FULL, `resp_ready`=1 and an accept in the same cycle → stays FULL with the new result (back-to-back).
  - FULL, `resp_ready`=1, no accept → EMPTY.
  - FULL, `resp_ready`=0 → stays FULL. All `resp_*` outputs hold and both readies are low.
- **Arithmetic:** results are 4-bit. ADD wraps, e.g. 4'hF+4'h1 = 4'h0, and the carry is bit 4 of the 5-bit sum. For AND, OR and XOR the carry is 0.
- **Operand sampling:** operands are sampled only in the accept cycle. A requester holds valid and operands stable until it sees ready. Dropping valid before acceptance is allowed and is simply not served.
- **`op_count`:** increments by 1 on every consumed result (`resp_valid` && `resp_ready`) and wraps from 255 to 0.
- **Reset:** when `rst_n` goes low, immediately, in any state or mid-transaction:
  - `resp_valid`=0, `resp_data`=0, `resp_id`=0, `resp_carry`=0;
  - `op_count`=0, `last_id`=1;
  - any in-flight result is discarded.
- **Readies during reset:** both readies are 0 while `rst_n`=0.

## Timing
- **Latency:** a request accepted at edge k appears on `resp_*` right after edge k, so `resp_valid` is high in cycle k+1.
- **Throughput:** one result per cycle while `resp_ready` stays high.
- **Combinational paths:** `reqN_ready` depends combinationally on `resp_ready` and both `reqN_valid`. No other path from input to output is combinational.
- **Fairness:** under continuous contention, grants alternate 0,1,0,1…
- **Reset release:** the deassertion of `rst_n` is synchronized externally. The first accept can occur at the first rising edge after release.

## Configuration
- **Macro:** `ALU_ARB_CARRY_EN`.
- **Defined:** `resp_carry` is registered together with `resp_data` as described above.
- **Not defined:** the carry logic is omitted and `resp_carry` is tied to 0. The port list is identical in both builds.

## Test plan
- **Single request:** after reset, req0 {a=3, b=5, op=11} and `resp_ready`=1.
  - The request is accepted in the first cycle.
  - Next cycle: `resp_valid`=1, `resp_data`=8, `resp_id`=0, carry=0.
  - After consumption, `op_count`=1.
- **ADD wrap and logic ops:** sequential requests (req0 ADD, then XOR, then AND, then OR, each accepted after the previous result is consumed).
  - ADD F+1 → `resp_data`=0, carry=1 with the macro, 0 without.
  - XOR A^F=5, AND C&A=8, OR C|3=F, each with carry=0.
- **Contention:** both requesters valid continuously for 6 cycles, `resp_ready`=1.
  - `resp_id` sequence is 0,1,0,1,0,1.
  - Each requester sees exactly 3 readies.
- **Backpressure:** `resp_ready`=0 for 4 cycles while both requesters are valid.
  - `resp_valid` stays 1 and `resp_*` are stable.
  - Both readies stay 0.
  - After `resp_ready` rises, the next result appears the following cycle with no gap.
- **Reset mid-transaction:** assert `rst_n`=0 asynchronously while FULL with `resp_data`=7.
  - All outputs go to their reset values immediately.
  - After release, the first tie is granted to requester 0.
- **Counter wrap:** consume 256 results.
  - `op_count` goes 255 → 0.
  - The 257th result gives `op_count`=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 4-bit ALU with a registered result slot.
// Optional feature: define ALU_ARB_CARRY_EN to register the ADD carry-out on resp_carry.
module alu_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_op,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [3:0] resp_data,
  output logic       resp_id,
  output logic       resp_carry,
  output logic [7:0] op_count
);

  typedef enum logic {StEmpty, StFull} state_e;

`ifdef ALU_ARB_CARRY_EN
  localparam int unsigned SumW = 5;
`else
  localparam int unsigned SumW = 4;
`endif

  state_e          state_q, state_d;
  logic            last_id_q;
  logic [3:0]      data_q;
  logic            id_q;
  logic [7:0]      count_q;
  logic            slot_free, grant0, grant1, accept;
  logic [3:0]      op_a, op_b, alu_res;
  logic [1:0]      op_sel;
  logic [SumW-1:0] sum;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    slot_free  = (state_q == StEmpty) || resp_ready;
    grant0     = req0_valid && (!req1_valid || last_id_q);
    grant1     = req1_valid && (!req0_valid || !last_id_q);
    req0_ready = rst_n && slot_free && grant0;
    req1_ready = rst_n && slot_free && grant1;
    accept     = req0_ready || req1_ready;
  end

  always_comb begin
    op_a   = req1_ready ? req1_a  : req0_a;
    op_b   = req1_ready ? req1_b  : req0_b;
    op_sel = req1_ready ? req1_op : req0_op;
    sum    = SumW'(op_a) + SumW'(op_b);
    unique case (op_sel)
      2'b00:   alu_res = op_a & op_b;
      2'b01:   alu_res = op_a | op_b;
      2'b10:   alu_res = op_a ^ op_b;
      default: alu_res = sum[3:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (resp_ready && !accept) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      last_id_q <= 1'b1;
      data_q    <= 4'h0;
      id_q      <= 1'b0;
      count_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_id_q <= req1_ready;
        data_q    <= alu_res;
        id_q      <= req1_ready;
      end
      if ((state_q == StFull) && resp_ready) count_q <= count_q + 8'd1;
    end
  end

`ifdef ALU_ARB_CARRY_EN
  logic carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (accept) begin
      carry_q <= (op_sel == 2'b11) && sum[SumW-1];
    end
  end

  assign resp_carry = carry_q;
`else
  assign resp_carry = 1'b0;
`endif

  assign resp_valid = (state_q == StFull);
  assign resp_data  = data_q;
  assign resp_id    = id_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; expected values are hand-computed per vector.
module tb_alu_arbiter;

`ifdef ALU_ARB_CARRY_EN
  localparam logic CarryEn = 1'b1;
`else
  localparam logic CarryEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic       resp_valid, resp_ready, resp_id, resp_carry;
  logic [3:0] resp_data;
  logic [7:0] op_count;

  int n_checks = 0;
  int n_errors = 0;
  int cnt0, cnt1;

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_carry (resp_carry),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single requester-0 operation with the consumer always ready.
  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] op, input logic [3:0] exp_d, input logic exp_c);
    req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    #1;
    check({tag, "_ready"}, req0_ready, 1);
    step();
    req0_valid = 1'b0;
    check({tag, "_valid"}, resp_valid, 1);
    check({tag, "_data"}, resp_data, exp_d);
    check({tag, "_carry"}, resp_carry, exp_c);
    step();
    check({tag, "_empty"}, resp_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; resp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'h0; req0_b = 4'h0; req0_op = 2'b00;
    req1_valid = 1'b1; req1_a = 4'h0; req1_b = 4'h0; req1_op = 2'b00;
    step(); step();
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_data", resp_data, 0);
    check("rst_id", resp_id, 0);
    check("rst_carry", resp_carry, 0);
    check("rst_count", op_count, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    resp_ready = 1'b1;

    // Single request: 3 + 5
    do_op("single", 4'h3, 4'h5, 2'b11, 4'h8, 1'b0);
    check("single_count", op_count, 1);

    // ADD wrap and logic ops
    do_op("add_wrap", 4'hF, 4'h1, 2'b11, 4'h0, CarryEn);
    do_op("xor", 4'hA, 4'hF, 2'b10, 4'h5, 1'b0);
    do_op("and", 4'hC, 4'hA, 2'b00, 4'h8, 1'b0);
    do_op("or", 4'hC, 4'h3, 2'b01, 4'hF, 1'b0);
    check("seq_count", op_count, 5);

    // Requester 1 alone: 9 + 8 wraps to 1
    req1_a = 4'h9; req1_b = 4'h8; req1_op = 2'b11; req1_valid = 1'b1;
    #1;
    check("r1_ready1", req1_ready, 1);
    check("r1_ready0", req0_ready, 0);
    step();
    req1_valid = 1'b0;
    check("r1_data", resp_data, 4'h1);
    check("r1_id", resp_id, 1);
    check("r1_carry", resp_carry, CarryEn);
    step();
    check("r1_count", op_count, 6);

    // Contention: req0 yields 2, req1 yields 4
    req0_a = 4'h1; req0_b = 4'h1; req0_op = 2'b11;
    req1_a = 4'h2; req1_b = 4'h2; req1_op = 2'b11;
    req0_valid = 1'b1; req1_valid = 1'b1;
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (req0_ready) cnt0++;
      if (req1_ready) cnt1++;
      step();
      check($sformatf("cont_id%0d", i), resp_id, i % 2);
      check($sformatf("cont_data%0d", i), resp_data, (i % 2) ? 4'h4 : 4'h2);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("cont_cnt0", cnt0, 3);
    check("cont_cnt1", cnt1, 3);
    step();
    check("cont_empty", resp_valid, 0);
    check("cont_count", op_count, 12);

    // Backpressure with both requesters pending
    resp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_ready0_%0d", i), req0_ready, 0);
      check($sformatf("bp_ready1_%0d", i), req1_ready, 0);
      check($sformatf("bp_valid%0d", i), resp_valid, 1);
      check($sformatf("bp_data%0d", i), resp_data, 4'h2);
      check($sformatf("bp_id%0d", i), resp_id, 0);
      step();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_rel_ready1", req1_ready, 1);
    check("bp_rel_ready0", req0_ready, 0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("bp_next_valid", resp_valid, 1);
    check("bp_next_id", resp_id, 1);
    check("bp_next_data", resp_data, 4'h4);
    step();
    check("bp_count", op_count, 14);

    // Reset while FULL holding 7
    resp_ready = 1'b0;
    req0_a = 4'h3; req0_b = 4'h4; req0_op = 2'b11; req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    check("mid_data", resp_data, 4'h7);
    check("mid_valid", resp_valid, 1);
    req0_a = 4'h1; req0_b = 4'h1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", resp_valid, 0);
    check("mid_rst_data", resp_data, 0);
    check("mid_rst_id", resp_id, 0);
    check("mid_rst_count", op_count, 0);
    check("mid_rst_ready0", req0_ready, 0);
    check("mid_rst_ready1", req1_ready, 0);
    step();
    rst_n = 1'b1;
    resp_ready = 1'b1;
    #1;
    check("post_rst_ready0", req0_ready, 1);
    check("post_rst_ready1", req1_ready, 0);
    step();
    check("post_rst_id", resp_id, 0);
    check("post_rst_data", resp_data, 4'h2);
    req1_valid = 1'b0;

    // Counter wrap: requester 0 streams with consumer always ready
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 258; k++) begin
      step();
      if (k == 256) check("wrap_255", op_count, 255);
      if (k == 257) check("wrap_0", op_count, 0);
      if (k == 258) check("wrap_1", op_count, 1);
    end
    req0_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
